// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control bundle between the control unit and the
// program-counter sequencer.
//
// Signals:
//   op          3           operation select (control unit -> sequencer)
//   cond        1           branch condition (control unit -> sequencer)
//   new_address ADDR_WIDTH  jump/branch/call target (control unit -> sequencer)
//   address     ADDR_WIDTH  registered fetch address (sequencer -> control unit)
//   stall       1           delay still in progress (sequencer -> control unit)
//   stack_depth DEPTH_W     valid return-stack entries (sequencer -> control unit)
//   overflow    1           sticky: CALL on full stack (sequencer -> control unit)
//   underflow   1           sticky: RET on empty stack (sequencer -> control unit)
//
// Modports: master = control unit side, slave = sequencer side.
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 8
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [2:0]            op;
    logic                  cond;
    logic [ADDR_WIDTH-1:0] new_address;
    logic [ADDR_WIDTH-1:0] address;
    logic                  stall;
    logic [DEPTH_W-1:0]    stack_depth;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output op, cond, new_address,
        input  address, stall, stack_depth, overflow, underflow
    );

    modport slave (
        input  op, cond, new_address,
        output address, stall, stack_depth, overflow, underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the instruction-fetch path.
// Each cycle the fetch address is updated according to a 3-bit opcode:
// HOLD, INCREASE, JUMP, DELAY (throttled increment), BRANCH, CALL, RET.
//
// Ports:
//   clock  in  rising-edge clock
//   reset  in  synchronous, active-high reset
//   bus    pc_sequencer_if.slave (op, cond, new_address in;
//          address, stall, stack_depth, overflow, underflow out)
//
// Configuration macro: PC_SEQUENCER_CALL_STACK_EN
//   defined   -> hardware return-address stack with CALL/RET and sticky
//                overflow/underflow flags
//   undefined -> no stack; CALL acts as JUMP, RET acts as HOLD, and
//                stack_depth/overflow/underflow read 0
module pc_sequencer #(
    parameter int ADDR_WIDTH   = 12,
    parameter int STACK_DEPTH  = 8,
    parameter int DELAY_CYCLES = 750000
) (
    input logic           clock,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int DCNT_W  = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [DCNT_W-1:0]     DCNT_LAST = DCNT_W'(DELAY_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_JUMP   = 3'd2,
        OP_DELAY  = 3'd3,
        OP_BRANCH = 3'd4,
        OP_CALL   = 3'd5,
        OP_RET    = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    op_e                   op;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
    logic                  delay_last;

    assign op         = op_e'(bus.op);
    assign addr_inc   = address_q + ADDR_ONE;
    assign delay_last = (dcnt_q == DCNT_LAST);

    assign bus.address = address_q;
    assign bus.stall   = (op == OP_DELAY) && !delay_last;

`ifdef PC_SEQUENCER_CALL_STACK_EN
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // Stack storage carries no reset: entries above depth are never read.
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [DEPTH_W-1:0]    top_idx;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push;
    logic                  stack_full;
    logic                  stack_empty;

    assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);
    assign top_idx     = depth_q - DEPTH_W'(1);

    assign bus.stack_depth = depth_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
`else
    assign bus.stack_depth = '0;
    assign bus.overflow    = 1'b0;
    assign bus.underflow   = 1'b0;
`endif

    always_comb begin
        address_d = address_q;
        // Any non-DELAY cycle restarts the delay count.
        dcnt_d    = '0;
`ifdef PC_SEQUENCER_CALL_STACK_EN
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push        = 1'b0;
`endif
        case (op)
            OP_INC:    address_d = addr_inc;
            OP_JUMP:   address_d = bus.new_address;
            OP_DELAY: begin
                if (delay_last) begin
                    address_d = addr_inc;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            OP_BRANCH: address_d = bus.cond ? bus.new_address : addr_inc;
`ifdef PC_SEQUENCER_CALL_STACK_EN
            OP_CALL: begin
                if (stack_full) begin
                    overflow_d = 1'b1;
                end else begin
                    push      = 1'b1;
                    depth_d   = depth_q + DEPTH_W'(1);
                    address_d = bus.new_address;
                end
            end
            OP_RET: begin
                if (stack_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    depth_d   = top_idx;
                    address_d = stack_q[top_idx[IDX_W-1:0]];
                end
            end
`else
            OP_CALL:   address_d = bus.new_address;
`endif
            default:   address_d = address_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            address_q <= '0;
            dcnt_q    <= '0;
`ifdef PC_SEQUENCER_CALL_STACK_EN
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`endif
        end else begin
            address_q <= address_d;
            dcnt_q    <= dcnt_d;
`ifdef PC_SEQUENCER_CALL_STACK_EN
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`endif
        end
    end

`ifdef PC_SEQUENCER_CALL_STACK_EN
    // The return address is the wrapped successor of the calling address.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            stack_q[depth_q[IDX_W-1:0]] <= addr_inc;
        end
    end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: drives two sequencers (DELAY_CYCLES=4 and DELAY_CYCLES=1,
// both ADDR_WIDTH=4, STACK_DEPTH=2) with the same directed-then-random
// opcode stream and compares every output against a queue-based model.
module tb_pc_sequencer;
    localparam int AW = 4;
    localparam int SD = 2;
    localparam int AMOD = 1 << AW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pc_sequencer_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) bus0 ();
    pc_sequencer_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) bus1 ();

    pc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .DELAY_CYCLES(4)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0)
    );
    pc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .DELAY_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, one slot per DUT.
    int m_addr[2];
    int m_dcnt[2];
    int m_ovf[2];
    int m_unf[2];
    int m_stk[2][$];
    int dcyc[2] = '{4, 1};

`ifdef PC_SEQUENCER_CALL_STACK_EN
    localparam bit STACK_ON = 1'b1;
`else
    localparam bit STACK_ON = 1'b0;
`endif

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit r, input int o, input bit c, input int na);
        if (r) begin
            m_addr[k] = 0;
            m_dcnt[k] = 0;
            m_ovf[k]  = 0;
            m_unf[k]  = 0;
            m_stk[k].delete();
            return;
        end
        if (o != 3) m_dcnt[k] = 0;
        case (o)
            1: m_addr[k] = (m_addr[k] + 1) % AMOD;
            2: m_addr[k] = na;
            3: begin
                if (m_dcnt[k] == dcyc[k] - 1) begin
                    m_addr[k] = (m_addr[k] + 1) % AMOD;
                    m_dcnt[k] = 0;
                end else begin
                    m_dcnt[k]++;
                end
            end
            4: m_addr[k] = c ? na : (m_addr[k] + 1) % AMOD;
            5: begin
                if (!STACK_ON) begin
                    m_addr[k] = na;
                end else if (m_stk[k].size() < SD) begin
                    m_stk[k].push_back((m_addr[k] + 1) % AMOD);
                    m_addr[k] = na;
                end else begin
                    m_ovf[k] = 1;
                end
            end
            6: begin
                if (STACK_ON) begin
                    if (m_stk[k].size() > 0) m_addr[k] = m_stk[k].pop_back();
                    else m_unf[k] = 1;
                end
            end
            default: ;
        endcase
    endtask

    // One clock: drive, check combinational stall, clock, check registered outputs.
    task automatic cycle(input bit r, input int o, input bit c, input int na);
        reset = r;
        bus0.op = 3'(o); bus0.cond = c; bus0.new_address = AW'(na);
        bus1.op = 3'(o); bus1.cond = c; bus1.new_address = AW'(na);
        #1;
        chk("stall0", int'(bus0.stall), int'(o == 3 && m_dcnt[0] != dcyc[0] - 1));
        chk("stall1", int'(bus1.stall), int'(o == 3 && m_dcnt[1] != dcyc[1] - 1));
        @(posedge clock);
        model_step(0, r, o, c, na);
        model_step(1, r, o, c, na);
        #1;
        chk("addr0",  int'(bus0.address),     m_addr[0]);
        chk("depth0", int'(bus0.stack_depth), m_stk[0].size());
        chk("ovf0",   int'(bus0.overflow),    m_ovf[0]);
        chk("unf0",   int'(bus0.underflow),   m_unf[0]);
        chk("addr1",  int'(bus1.address),     m_addr[1]);
        chk("depth1", int'(bus1.stack_depth), m_stk[1].size());
        chk("ovf1",   int'(bus1.overflow),    m_ovf[1]);
        chk("unf1",   int'(bus1.underflow),   m_unf[1]);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = 0; m_dcnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        end
        bus0.op = '0; bus0.cond = 1'b0; bus0.new_address = '0;
        bus1.op = '0; bus1.cond = 1'b0; bus1.new_address = '0;
        @(posedge clock);
        #1;

        // Reset, then 17 increments through the 4-bit wrap.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("reset_addr", int'(bus0.address), 0);
        for (int i = 0; i < 17; i++) cycle(0, 1, 0, 0);
        chk("wrap_addr", int'(bus0.address), 1);

        // Throttled increment from 5, then an interrupted delay.
        cycle(0, 2, 0, 5);
        for (int i = 0; i < 8; i++) cycle(0, 3, 0, 0);
        chk("delay8_addr", int'(bus0.address), 7);
        cycle(0, 2, 0, 5);
        cycle(0, 3, 0, 0);
        cycle(0, 3, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 3, 0, 0);
        chk("delay_restart_addr", int'(bus0.address), 6);

        // Branch not taken, then taken.
        cycle(0, 2, 0, 10);
        cycle(0, 4, 0, 4);
        chk("branch_nt", int'(bus0.address), 11);
        cycle(0, 4, 1, 4);
        chk("branch_t", int'(bus0.address), 4);

        // Nested call/return, then overflow and underflow.
        cycle(0, 2, 0, 3);
        cycle(0, 5, 0, 12);
        cycle(0, 5, 0, 14);
        cycle(0, 6, 0, 0);
        cycle(0, 6, 0, 0);
        cycle(0, 5, 0, 8);
        cycle(0, 5, 0, 9);
        cycle(0, 5, 0, 2);
        cycle(0, 6, 0, 0);
        cycle(0, 6, 0, 0);
        cycle(0, 6, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);

        // Reset in the middle of a delay with one return address pending.
        cycle(1, 0, 0, 0);
        cycle(0, 5, 0, 7);
        cycle(0, 3, 0, 0);
        cycle(0, 3, 0, 0);
        cycle(1, 3, 0, 0);
        chk("reset_mid_addr", int'(bus0.address), 0);
        cycle(0, 3, 0, 0);
        chk("delay1_addr", int'(bus1.address), 1);

        // Randomized stream biased toward DELAY and stack traffic.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            int o;
            bit r;
            sel = $urandom_range(0, 15);
            case (sel)
                0, 1, 2, 3, 4: o = 3;
                5, 6:          o = 5;
                7, 8:          o = 6;
                default:       o = $urandom_range(0, 7);
            endcase
            r = ($urandom_range(0, 63) == 0);
            cycle(r, o, 1'($urandom_range(0, 1)), $urandom_range(0, AMOD - 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
